// File: rtl/sharp_coef_sched.sv
// ---------------------------------------------------------------------------
// sharp_coef_sched
//
// Frame-boundary scheduler for the sharpening filter's coefficient input.
// It forwards the upstream stream handshake to the filter. After the last
// input beat of a frame it closes the gate. The gate stays closed until that
// frame's EOF leaves the filter output, or until a drain timeout expires. In
// one UPDATE cycle inside that gap, the live coefficient moves one step
// toward a software-set target. The coefficient therefore never changes
// mid-frame, and sharpening can fade in or out over several frames.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_wr                one-cycle strobe latching cfg_target / cfg_step
//   cfg_target            requested final coefficient
//   cfg_step              per-frame increment (0 = jump to target)
//   s_val / s_rdy         upstream handshake (from the window generator)
//   s_sof / s_eof         upstream frame markers
//   f_val / f_rdy         handshake toward the filter input
//   mon_val/mon_rdy/mon_eof  tap on the filter output handshake
//   coef_out              live coefficient to the filter (registered)
//   frame_cnt             completed-frame count, wraps
//   ramp_done             coef_out equals the latched target
//   busy                  scheduler is in DRAIN or UPDATE
//   err_timeout           sticky drain-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module sharp_coef_sched #(
  parameter int COEF_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int INIT_COEF     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [COEF_WIDTH-1:0] cfg_target,
  input  logic [COEF_WIDTH-1:0] cfg_step,
  input  logic                  s_val,
  output logic                  s_rdy,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic                  f_val,
  input  logic                  f_rdy,
  input  logic                  mon_val,
  input  logic                  mon_rdy,
  input  logic                  mon_eof,
  output logic [COEF_WIDTH-1:0] coef_out,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  ramp_done,
  output logic                  busy,
  output logic                  err_timeout
);

  // The timer counts 0 .. DRAIN_TIMEOUT-1.
  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TW-1:0]         TIMER_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [COEF_WIDTH-1:0] COEF_RST   = COEF_WIDTH'(INIT_COEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_UPDATE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q;
  logic [COEF_WIDTH-1:0] coef_q, coef_step_d;
  logic [COEF_WIDTH-1:0] target_q, step_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;
  logic                  err_q;

  logic gate_open, acc, oeof, timeout_hit;

  // Handshake gating: purely combinational, so that the filter sees no
  // extra latency. Data and sideband do not pass through this block.
  assign gate_open = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign f_val     = s_val & gate_open;
  assign s_rdy     = f_rdy & gate_open;
  assign acc       = s_val & s_rdy;
  assign oeof      = mon_val & mon_rdy & mon_eof;

  assign timeout_hit = (state_q == ST_DRAIN) && !oeof && (timer_q == TIMER_LAST);

  // Next-state logic. The output EOF is only looked at while in DRAIN. An
  // output EOF in the same cycle as the RUN->DRAIN transition therefore
  // belongs to an older frame and is ignored.
  always_comb begin
    // NOTE: assign a default to every always_comb output first, so that no
    // path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc && s_sof) state_d = s_eof ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (acc && s_eof) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (oeof || (timer_q == TIMER_LAST)) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Step arithmetic, done one bit wider than the coefficient so that the
  // sum cannot wrap. The down path clamps at zero before it is compared
  // with the target.
  logic [COEF_WIDTH:0] coef_x, tgt_x, step_x, up_sum, dn_diff;

  always_comb begin
    coef_x  = {1'b0, coef_q};
    tgt_x   = {1'b0, target_q};
    step_x  = {1'b0, step_q};
    up_sum  = coef_x + step_x;
    dn_diff = (step_x > coef_x) ? '0 : (coef_x - step_x);

    coef_step_d = coef_q;
    if (step_q == '0) begin
      coef_step_d = target_q;
    end else if (coef_x < tgt_x) begin
      coef_step_d = (up_sum > tgt_x) ? target_q : up_sum[COEF_WIDTH-1:0];
    end else if (coef_x > tgt_x) begin
      coef_step_d = (dn_diff < tgt_x) ? target_q : dn_diff[COEF_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values. This is also why a cfg_wr that
  // lands in the UPDATE cycle does not affect that cycle's step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      coef_q      <= COEF_RST;
      target_q    <= COEF_RST;
      step_q      <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
        timer_q <= '0;
      end else if (state_q == ST_DRAIN) begin
        timer_q <= timer_q + TW'(1);
      end

      if (cfg_wr) begin
        target_q <= cfg_target;
        step_q   <= cfg_step;
      end

      if (state_q == ST_UPDATE) begin
        coef_q      <= coef_step_d;
        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      end

      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign coef_out    = coef_q;
  assign frame_cnt   = frame_cnt_q;
  assign ramp_done   = (coef_q == target_q);
  assign busy        = (state_q == ST_DRAIN) || (state_q == ST_UPDATE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sharp_coef_sched.sv
// ---------------------------------------------------------------------------
// tb_sharp_coef_sched
//
// Directed bench for sharp_coef_sched. u_dut has a long drain timeout and
// covers the main behaviour. u_to has DRAIN_TIMEOUT=16, its output-EOF tap
// is tied off, and it is used only for the timeout scenario.
// ---------------------------------------------------------------------------
module tb_sharp_coef_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_wr;
  logic [7:0] cfg_target, cfg_step;
  logic       s_val, s_sof, s_eof, f_rdy;
  logic       mon_val, mon_rdy, mon_eof;
  logic       s_rdy, f_val, ramp_done, busy, err_timeout;
  logic [7:0] coef_out;
  logic [15:0] frame_cnt;

  // Timeout instance signals.
  logic       t_s_val, t_s_sof, t_s_eof;
  logic       t_s_rdy, t_f_val, t_ramp_done, t_busy, t_err;
  logic [7:0] t_coef;
  logic [15:0] t_frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sharp_coef_sched #(
    .COEF_WIDTH(8), .CNT_WIDTH(16), .DRAIN_TIMEOUT(64), .INIT_COEF(64)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_target(cfg_target), .cfg_step(cfg_step),
    .s_val(s_val), .s_rdy(s_rdy), .s_sof(s_sof), .s_eof(s_eof),
    .f_val(f_val), .f_rdy(f_rdy),
    .mon_val(mon_val), .mon_rdy(mon_rdy), .mon_eof(mon_eof),
    .coef_out(coef_out), .frame_cnt(frame_cnt), .ramp_done(ramp_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  sharp_coef_sched #(
    .COEF_WIDTH(8), .CNT_WIDTH(16), .DRAIN_TIMEOUT(16), .INIT_COEF(64)
  ) u_to (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(1'b0), .cfg_target(8'd0), .cfg_step(8'd0),
    .s_val(t_s_val), .s_rdy(t_s_rdy), .s_sof(t_s_sof), .s_eof(t_s_eof),
    .f_val(t_f_val), .f_rdy(1'b1),
    .mon_val(1'b0), .mon_rdy(1'b1), .mon_eof(1'b0),
    .coef_out(t_coef), .frame_cnt(t_frame_cnt), .ramp_done(t_ramp_done),
    .busy(t_busy), .err_timeout(t_err)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] tgt, input logic [7:0] stp);
    cfg_wr = 1'b1; cfg_target = tgt; cfg_step = stp;
    tick();
    cfg_wr = 1'b0;
  endtask

  // Sends one frame of `beats` beats. The filter-output EOF is returned
  // after `drain` DRAIN cycles. While the gate is closed, upstream keeps
  // offering the next SOF. `bad` counts cycles with the wrong gating or busy
  // value. `moved` counts cycles where the coefficient differed from its
  // value at frame start, before the final UPDATE edge.
  task automatic run_frame(input int beats, input int drain, input bit stale_eof,
                           output int bad, output int moved);
    logic [7:0] c0;
    c0 = coef_out; bad = 0; moved = 0;
    f_rdy = 1'b1; mon_rdy = 1'b1;
    for (int i = 0; i < beats; i++) begin
      s_val = 1'b1; s_sof = (i == 0); s_eof = (i == beats - 1);
      mon_val = stale_eof && (i == beats - 1); mon_eof = mon_val;
      #1;
      if (s_rdy !== 1'b1 || f_val !== 1'b1 || busy !== 1'b0) bad++;
      if (coef_out !== c0) moved++;
      tick();
    end
    s_sof = 1'b1; s_eof = 1'b0;
    for (int k = 0; k < drain; k++) begin
      mon_val = (k == drain - 1); mon_eof = mon_val;
      #1;
      if (s_rdy !== 1'b0 || f_val !== 1'b0 || busy !== 1'b1) bad++;
      if (coef_out !== c0) moved++;
      tick();
    end
    mon_val = 1'b0; mon_eof = 1'b0;
    #1;
    if (s_rdy !== 1'b0 || f_val !== 1'b0 || busy !== 1'b1) bad++;
    if (coef_out !== c0) moved++;
    tick();
    s_val = 1'b0; s_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_wr = 0; cfg_target = 0; cfg_step = 0;
    s_val = 0; s_sof = 0; s_eof = 0; f_rdy = 0;
    mon_val = 0; mon_rdy = 1; mon_eof = 0;
    t_s_val = 0; t_s_sof = 0; t_s_eof = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (coef_out !== 8'd64) $display("FAIL reset_coef got=%0d exp=64", coef_out); else n_pass++;
    n_checks++; if (ramp_done !== 1'b1) $display("FAIL reset_ramp_done got=%b exp=1", ramp_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_timeout); else n_pass++;
    n_checks++; if (s_rdy !== 1'b0) $display("FAIL reset_s_rdy_low got=%b exp=0", s_rdy); else n_pass++;
    f_rdy = 1'b1; #1;
    n_checks++; if (s_rdy !== 1'b1) $display("FAIL reset_s_rdy_high got=%b exp=1", s_rdy); else n_pass++;
    s_val = 1'b1; #1;
    n_checks++; if (f_val !== 1'b1) $display("FAIL reset_f_val got=%b exp=1", f_val); else n_pass++;
    s_val = 1'b0;
  endtask

  task automatic test_ramp_up();
    int bad, moved;
    logic [7:0] exp_c [3];
    exp_c[0] = 8'd80; exp_c[1] = 8'd96; exp_c[2] = 8'd100;
    cfg_write(8'd100, 8'd16);
    n_checks++; if (ramp_done !== 1'b0) $display("FAIL ramp_pending got=%b exp=0", ramp_done); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      run_frame(16, 3, 1'b0, bad, moved);
      n_checks++; if (coef_out !== exp_c[f]) $display("FAIL ramp_coef%0d got=%0d exp=%0d", f, coef_out, exp_c[f]); else n_pass++;
      n_checks++; if (bad !== 0 || moved !== 0) $display("FAIL ramp_frame%0d bad=%0d moved=%0d exp=0/0", f, bad, moved); else n_pass++;
    end
    n_checks++; if (ramp_done !== 1'b1) $display("FAIL ramp_done got=%b exp=1", ramp_done); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd3) $display("FAIL ramp_frame_cnt got=%0d exp=3", frame_cnt); else n_pass++;
  endtask

  task automatic test_jump_down();
    int bad, moved;
    logic [7:0] exp_c [3];
    exp_c[0] = 8'd3; exp_c[1] = 8'd0; exp_c[2] = 8'd0;
    cfg_write(8'd10, 8'd0);
    run_frame(4, 2, 1'b0, bad, moved);
    n_checks++; if (coef_out !== 8'd10) $display("FAIL jump_coef got=%0d exp=10", coef_out); else n_pass++;
    cfg_write(8'd0, 8'd7);
    for (int f = 0; f < 3; f++) begin
      run_frame(4, 2, 1'b0, bad, moved);
      n_checks++; if (coef_out !== exp_c[f]) $display("FAIL down_coef%0d got=%0d exp=%0d", f, coef_out, exp_c[f]); else n_pass++;
    end
    n_checks++; if (ramp_done !== 1'b1) $display("FAIL down_ramp_done got=%b exp=1", ramp_done); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd7) $display("FAIL down_frame_cnt got=%0d exp=7", frame_cnt); else n_pass++;
  endtask

  // s_val stays high across the boundary. A stale output EOF coincides with
  // the last input beat. DRAIN then lasts 20 cycles, and the second frame's
  // SOF must be accepted in the first cycle after UPDATE.
  task automatic test_drain_gating();
    int bad, moved;
    run_frame(4, 20, 1'b1, bad, moved);
    n_checks++; if (bad !== 0) $display("FAIL gate_closed bad_cycles=%0d exp=0", bad); else n_pass++;
    run_frame(4, 2, 1'b0, bad, moved);
    n_checks++; if (bad !== 0) $display("FAIL gate_reopen bad_cycles=%0d exp=0", bad); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd9) $display("FAIL gate_frame_cnt got=%0d exp=9", frame_cnt); else n_pass++;
  endtask

  task automatic test_midframe_cfg_reset();
    f_rdy = 1'b1; mon_rdy = 1'b1;
    // Frame A: SOF, then a second SOF together with a config write, then EOF.
    s_val = 1; s_sof = 1; s_eof = 0; tick();
    cfg_wr = 1; cfg_target = 8'd200; cfg_step = 8'd50; tick();
    cfg_wr = 0; s_sof = 0;
    n_checks++; if (coef_out !== 8'd0) $display("FAIL mid_coef_run got=%0d exp=0", coef_out); else n_pass++;
    n_checks++; if (ramp_done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_run_flags ramp=%b busy=%b exp=0/0", ramp_done, busy); else n_pass++;
    s_eof = 1; tick();
    s_val = 0; s_eof = 0;
    n_checks++; if (busy !== 1'b1 || coef_out !== 8'd0) $display("FAIL mid_drain busy=%b coef=%0d exp=1/0", busy, coef_out); else n_pass++;
    mon_val = 1; mon_eof = 1; tick();
    mon_val = 0; mon_eof = 0; tick();
    n_checks++; if (coef_out !== 8'd50) $display("FAIL mid_update_coef got=%0d exp=50", coef_out); else n_pass++;

    // Frame B: one-beat frame, then reset while in DRAIN.
    s_val = 1; s_sof = 1; s_eof = 1; tick();
    s_val = 0; s_sof = 0; s_eof = 0; s_val = 1;
    tick();
    rst_n = 1'b0; #1;
    n_checks++; if (coef_out !== 8'd64 || frame_cnt !== 16'd0) $display("FAIL rst_values coef=%0d cnt=%0d exp=64/0", coef_out, frame_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0 || ramp_done !== 1'b1) $display("FAIL rst_flags busy=%b ramp=%b exp=0/1", busy, ramp_done); else n_pass++;
    n_checks++; if (s_rdy !== 1'b1 || f_val !== 1'b1) $display("FAIL rst_gate s_rdy=%b f_val=%b exp=1/1", s_rdy, f_val); else n_pass++;
    s_val = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();

    // A non-SOF beat in IDLE passes through and does not start a frame.
    s_val = 1; s_sof = 0; s_eof = 1; #1;
    n_checks++; if (s_rdy !== 1'b1 || f_val !== 1'b1) $display("FAIL idle_pass s_rdy=%b f_val=%b exp=1/1", s_rdy, f_val); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_sof busy=%b exp=0", busy); else n_pass++;
    s_sof = 1; tick();
    s_val = 0; s_sof = 0; s_eof = 0;
    n_checks++; if (busy !== 1'b1) $display("FAIL idle_sof_eof busy=%b exp=1", busy); else n_pass++;
    mon_val = 1; mon_eof = 1; tick();
    mon_val = 0; mon_eof = 0; tick();
    n_checks++; if (frame_cnt !== 16'd1 || coef_out !== 8'd64) $display("FAIL post_rst_frame cnt=%0d coef=%0d exp=1/64", frame_cnt, coef_out); else n_pass++;
  endtask

  // u_to: DRAIN is entered at edge E0. The timer reaches 15 in the 16th
  // DRAIN cycle, UPDATE follows it, and frame_cnt moves on the next edge.
  task automatic test_timeout();
    int bad;
    for (int f = 0; f < 2; f++) begin
      bad = 0;
      t_s_val = 1; t_s_sof = 1; t_s_eof = 1; tick();
      t_s_val = 0; t_s_sof = 0; t_s_eof = 0;
      for (int k = 0; k < 16; k++) begin
        if (t_busy !== 1'b1 || t_s_rdy !== 1'b0 || t_frame_cnt !== 16'(f)) bad++;
        if (f == 0 && t_err !== 1'b0) bad++;
        tick();
      end
      n_checks++; if (bad !== 0) $display("FAIL to_drain%0d bad_cycles=%0d exp=0", f, bad); else n_pass++;
      n_checks++; if (t_busy !== 1'b1 || t_err !== 1'b1) $display("FAIL to_update%0d busy=%b err=%b exp=1/1", f, t_busy, t_err); else n_pass++;
      tick();
      n_checks++; if (t_frame_cnt !== 16'(f + 1) || t_busy !== 1'b0) $display("FAIL to_done%0d cnt=%0d busy=%b exp=%0d/0", f, t_frame_cnt, t_busy, f + 1); else n_pass++;
    end
    n_checks++; if (t_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", t_err); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL main_no_timeout got=%b exp=0", err_timeout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_jump_down();
    test_drain_gating();
    test_midframe_cfg_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sharp_coef_sched.md
Name: sharp_coef_sched

Overview:
- Frame-boundary scheduler for the sharpening filter's coefficient input.
- Passes the 3x3 stream handshake to the filter. After each frame's last input beat, it blocks new input until the frame's EOF leaves the filter output.
- In that gap it steps the live coefficient one increment toward a software-set target, so the coefficient never changes mid-frame and sharpening can fade in or out over several frames.
- Sits between the window generator and the filter; drives the filter's coefficient port.

Parameters:
COEF_WIDTH, 8, coefficient width
CNT_WIDTH, 16, frame counter width
DRAIN_TIMEOUT, 4096, max cycles in DRAIN before forced update
INIT_COEF, 64, coefficient and target value after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
cfg_wr  in  1  one-cycle strobe: latch cfg_target and cfg_step
cfg_target  in  COEF_WIDTH  requested final coefficient
cfg_step  in  COEF_WIDTH  per-frame increment; 0 means jump straight to target
s_val  in  1  upstream beat valid
s_rdy  out  1  ready to upstream
s_sof  in  1  start of frame on upstream beat
s_eof  in  1  end of frame on upstream beat
f_val  out  1  valid to filter input
f_rdy  in  1  filter input ready
mon_val  in  1  filter output valid (tap)
mon_rdy  in  1  filter output ready (tap)
mon_eof  in  1  filter output end of frame (tap)
coef_out  out  COEF_WIDTH  live coefficient to filter, registered
frame_cnt  out  CNT_WIDTH  completed-frame count, registered, wraps at max
ramp_done  out  1  coef_out equals latched target
busy  out  1  state is DRAIN or UPDATE
err_timeout  out  1  sticky; set on DRAIN timeout, cleared only by reset

Behaviour:
- Reset (asynchronous): state IDLE, coef_out=INIT_COEF, target=INIT_COEF, step=0, frame_cnt=0, timer=0, err_timeout=0.
- Gate: gate_open = (state is IDLE or RUN).
  - f_val = s_val & gate_open.
  - s_rdy = f_rdy & gate_open.
  - Both are combinational. Data and sideband are not routed through this block.
- Beat accepted: acc = s_val & s_rdy.
- Output EOF seen: oeof = mon_val & mon_rdy & mon_eof.
- IDLE:
  - acc & s_sof & ~s_eof -> RUN.
  - acc & s_sof & s_eof -> DRAIN.
  - Beats without SOF pass through; state does not change.
- RUN:
  - acc & s_eof -> DRAIN.
  - A second SOF while in RUN is ignored; state stays RUN.
- DRAIN:
  - Gate closed. Timer increments each cycle and is cleared on entry.
  - oeof -> UPDATE.
  - timer == DRAIN_TIMEOUT-1 without oeof -> UPDATE, and err_timeout is set.
- UPDATE (exactly one cycle, gate closed):
  - coef_out is stepped toward target; frame_cnt increments; next state is IDLE.
  - Same-cycle oeof in the RUN->DRAIN transition cycle is not recorded; DRAIN always waits for a fresh oeof.
- Step arithmetic, evaluated in COEF_WIDTH+1 bits (no wrap):
  - step == 0: coef_out <= target.
  - coef_out < target: coef_out <= min(coef_out + step, target).
  - coef_out > target: coef_out <= max(coef_out - step, target); the subtraction clamps at 0 and never underflows.
  - coef_out == target: no change.
- cfg_wr: target and step register on the next edge in any state.
  - A write landing in the UPDATE cycle does not affect that cycle's step; UPDATE uses the values registered before it.
  - Writes never change coef_out directly.
- ramp_done = (coef_out == target). It is combinational from registers.
- Throughput: one idle cycle per frame for UPDATE, plus the filter pipeline drain time.
- Reset mid-frame: gate reopens in IDLE. The next input beat is accepted in IDLE; if it is not an SOF it passes through while the block waits for an SOF.

Test Plan:
- Reset values: release rst_n with no traffic -> coef_out=64, ramp_done=1, busy=0, frame_cnt=0, err_timeout=0, s_rdy follows f_rdy.
- Upward ramp: cfg_wr target=100 step=16; send 3 frames of 4x4 -> coef_out reads 80, 96, 100 after successive UPDATE cycles. ramp_done=1 after the 3rd frame. coef_out is constant during every frame.
- Jump and downward clamp: step=0 target=10 -> coef_out=10 after one frame. Then target=0 step=7 -> 3, then 0, with no underflow.
- Drain gating: assert s_val continuously across a frame boundary; delay mon_eof 20 cycles after input EOF -> s_rdy=0 and f_val=0 for all 21 DRAIN+UPDATE cycles; the next SOF is accepted in the cycle after UPDATE.
- Timeout: suppress mon_eof, DRAIN_TIMEOUT=16 -> UPDATE occurs 16 cycles after DRAIN entry, err_timeout=1 and stays 1 over later frames.
- Mid-frame config and reset: cfg_wr target=200 mid-RUN -> coef_out unchanged until UPDATE. Pulse rst_n low in DRAIN -> all reset values restored and the gate reopens immediately.
